// File: rtl/coproc_frame_sequencer_if.sv
// RX FIFO, coprocessor and UART TX handshake signals seen by the frame sequencer.
// The master modport is the sequencer side; the slave modport is the peripheral side.
interface coproc_frame_sequencer_if #(
  parameter int unsigned FRAME_BITS = 144
);
  logic                  rx_empty;
  logic [FRAME_BITS-1:0] rx_frame;
  logic                  rx_rd;
  logic [FRAME_BITS-1:0] cp_din;
  logic                  cp_din_valid;
  logic [FRAME_BITS-1:0] cp_dout;
  logic                  cp_dout_valid;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  tx_trigger;
  logic                  tx_busy;

  modport master (
    input  rx_empty, rx_frame, cp_dout, cp_dout_valid, tx_busy,
    output rx_rd, cp_din, cp_din_valid, tx_frame, tx_trigger
  );

  modport slave (
    output rx_empty, rx_frame, cp_dout, cp_dout_valid, tx_busy,
    input  rx_rd, cp_din, cp_din_valid, tx_frame, tx_trigger
  );
endinterface

// File: rtl/coproc_frame_sequencer.sv
// Moves one UART frame through the coprocessor and back out of the UART TX,
// with a manual "resend last result" path and sticky timeout reporting.
module coproc_frame_sequencer #(
  parameter int unsigned FRAME_BITS     = 144,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TX_ACK_CYCLES  = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  coproc_frame_sequencer_if.master    bus,
  input  logic                        manual_send,
  output logic                        busy,
  output logic                        err_timeout,
  output logic [CNT_W-1:0]            frame_count
);

  localparam int unsigned CYC_MAX = (TIMEOUT_CYCLES > TX_ACK_CYCLES) ? TIMEOUT_CYCLES : TX_ACK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, COMPUTE, SEND, TX_ACK, TX_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_rd_q, rx_rd_d;
  logic                  cp_din_valid_q, cp_din_valid_d;
  logic                  tx_trigger_q, tx_trigger_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  man_q;
  logic                  man_edge;
  logic [FRAME_BITS-1:0] cp_din_q, cp_din_d;
  logic [FRAME_BITS-1:0] tx_frame_q, tx_frame_d;
  logic [CNT_W-1:0]      frame_count_q, frame_count_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  assign man_edge = manual_send & ~man_q;

  always_comb begin
    state_d        = state_q;
    rx_rd_d        = 1'b0;
    cp_din_valid_d = 1'b0;
    tx_trigger_d   = 1'b0;
    err_d          = err_q;
    cp_din_d       = cp_din_q;
    tx_frame_d     = tx_frame_q;
    frame_count_d  = frame_count_q;
    tmr_d          = tmr_q;
    case (state_q)
      IDLE: begin
        if (!bus.rx_empty) begin
          rx_rd_d = 1'b1;
          state_d = LOAD;
        end else if (man_edge && (frame_count_q != '0)) begin
          state_d = SEND;
        end
      end
      // rx_rd is high this cycle, so rx_frame is still the pre-pop head.
      LOAD: begin
        cp_din_d = bus.rx_frame;
        state_d  = ISSUE;
      end
      ISSUE: begin
        cp_din_valid_d = 1'b1;
        tmr_d          = '0;
        state_d        = COMPUTE;
      end
      // A ready transmitter is triggered straight from here to keep the result-to-trigger latency at one cycle.
      COMPUTE: begin
        if (bus.cp_dout_valid && !cp_din_valid_q) begin
          tx_frame_d = bus.cp_dout;
          if (!bus.tx_busy) begin
            tx_trigger_d = 1'b1;
            tmr_d        = '0;
            state_d      = TX_ACK;
          end else begin
            state_d = SEND;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_trigger_d = 1'b1;
          tmr_d        = '0;
          state_d      = TX_ACK;
        end
      end
      TX_ACK: begin
        if (bus.tx_busy) begin
          state_d = TX_DRAIN;
        end else if (tmr_q == TMR_W'(TX_ACK_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      TX_DRAIN: begin
        if (!bus.tx_busy) begin
          frame_count_d = frame_count_q + CNT_W'(1);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      rx_rd_q        <= 1'b0;
      cp_din_valid_q <= 1'b0;
      tx_trigger_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      man_q          <= 1'b0;
      cp_din_q       <= '0;
      tx_frame_q     <= '0;
      frame_count_q  <= '0;
      tmr_q          <= '0;
    end else begin
      state_q        <= state_d;
      rx_rd_q        <= rx_rd_d;
      cp_din_valid_q <= cp_din_valid_d;
      tx_trigger_q   <= tx_trigger_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      man_q          <= manual_send;
      cp_din_q       <= cp_din_d;
      tx_frame_q     <= tx_frame_d;
      frame_count_q  <= frame_count_d;
      tmr_q          <= tmr_d;
    end
  end

  assign bus.rx_rd        = rx_rd_q;
  assign bus.cp_din       = cp_din_q;
  assign bus.cp_din_valid = cp_din_valid_q;
  assign bus.tx_frame     = tx_frame_q;
  assign bus.tx_trigger   = tx_trigger_q;
  assign busy             = busy_q;
  assign err_timeout      = err_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_coproc_frame_sequencer.sv
// Directed bench for coproc_frame_sequencer with behavioural RX FIFO,
// coprocessor and UART TX responders.
module tb_coproc_frame_sequencer;
  localparam int unsigned FB = 144;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          manual_send;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] frame_count;

  coproc_frame_sequencer_if #(.FRAME_BITS(FB)) bus ();

  coproc_frame_sequencer #(
    .FRAME_BITS    (FB),
    .TIMEOUT_CYCLES(64),
    .TX_ACK_CYCLES (16),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .manual_send(manual_send),
    .busy       (busy),
    .err_timeout(err_timeout),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  logic          rx_empty_r      = 1'b1;
  logic [FB-1:0] rx_frame_r      = '0;
  logic [FB-1:0] cp_dout_r       = '0;
  logic          cp_dout_valid_r = 1'b0;
  logic          tx_busy_m       = 1'b0;
  logic          tx_force        = 1'b0;

  assign bus.rx_empty      = rx_empty_r;
  assign bus.rx_frame      = rx_frame_r;
  assign bus.cp_dout       = cp_dout_r;
  assign bus.cp_dout_valid = cp_dout_valid_r;
  assign bus.tx_busy       = tx_busy_m | tx_force;

  logic [FB-1:0] fifo [$];
  logic [FB-1:0] held    = '0;
  logic [FB-1:0] last_tx = '0;
  logic [FB-1:0] cp_mask = '0;
  logic          pop_req = 1'b0;
  logic          prev_rd = 1'b0, prev_val = 1'b0, prev_trig = 1'b0, inflight = 1'b0;
  int cyc = 0;
  int n_rd = 0, n_val = 0, n_trig = 0, viol = 0;
  int rd_cyc = -1000, val_cyc = -1000, trig_cyc = -1000;
  int cp_delay = 0, cd = 0, tx_len = 0, tx_rem = 0;
  logic cp_early = 1'b0;
  int total = 0, bad = 0;

  function automatic void refresh();
    rx_empty_r = (fifo.size() == 0);
    rx_frame_r = (fifo.size() != 0) ? fifo[0] : '0;
  endfunction

  always @(posedge clk) cyc++;

  // Pop after the edge that ends the rx_rd cycle.
  always @(posedge clk) begin
    #1;
    if (pop_req && fifo.size() != 0) begin
      void'(fifo.pop_front());
      refresh();
    end
  end

  always @(negedge clk) begin
    pop_req = bus.rx_rd;
    if (bus.rx_rd) begin
      n_rd++;
      rd_cyc = cyc;
      if (inflight || prev_rd) viol++;
      inflight = 1'b1;
    end else if (!busy) begin
      inflight = 1'b0;
    end
    if (bus.cp_din_valid) begin
      n_val++;
      val_cyc = cyc;
      if (prev_val) viol++;
    end
    if (bus.tx_trigger) begin
      n_trig++;
      trig_cyc = cyc;
      last_tx  = bus.tx_frame;
      if (prev_trig) viol++;
    end
    prev_rd   = bus.rx_rd;
    prev_val  = bus.cp_din_valid;
    prev_trig = bus.tx_trigger;

    cp_dout_valid_r = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        cp_dout_r       = held ^ cp_mask;
        cp_dout_valid_r = 1'b1;
      end
    end
    if (bus.cp_din_valid) begin
      held = bus.cp_din;
      if (cp_early) begin
        cp_dout_r       = ~bus.cp_din;
        cp_dout_valid_r = 1'b1;
      end
      if (cp_delay > 0) cd = cp_delay;
    end

    if (tx_rem > 0) begin
      tx_rem--;
      if (tx_rem == 0) tx_busy_m = 1'b0;
    end
    if (bus.tx_trigger && tx_len > 0) begin
      tx_busy_m = 1'b1;
      tx_rem    = tx_len;
    end
  end

  task automatic chk(input string tag, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    n_rd = 0; n_val = 0; n_trig = 0; viol = 0;
    rd_cyc = -1000; val_cyc = -1000; trig_cyc = -1000;
  endtask

  task automatic push(input logic [FB-1:0] f);
    fifo.push_back(f);
    refresh();
  endtask

  function automatic logic [FB-1:0] mkf(input logic [7:0] s);
    logic [FB-1:0] f = '0;
    for (int i = 0; i < 18; i++) f = (f << 8) | FB'(s + 8'(i));
    return f;
  endfunction

  logic [FB-1:0] fa, fb_, fc, fd, fe, ff, fg, fh, fi, fj, m;
  int rel;

  initial begin
    rst = 1'b0;
    manual_send = 1'b0;
    m  = {18{8'hA5}};
    fa = mkf(8'h01); fb_ = mkf(8'h20); fc = mkf(8'h40); fd = mkf(8'h60);
    fe = mkf(8'h80); ff = mkf(8'h90); fg = mkf(8'hB0); fh = mkf(8'hC0);
    fi = mkf(8'hD0); fj = mkf(8'hE0);
    run(3);
    chk("rst_busy", FB'(busy), '0);
    chk("rst_err", FB'(err_timeout), '0);
    chk("rst_cnt", FB'(frame_count), '0);
    chk("rst_rd", FB'(bus.rx_rd), '0);
    chk("rst_val", FB'(bus.cp_din_valid), '0);
    chk("rst_trig", FB'(bus.tx_trigger), '0);
    chk("rst_cp_din", bus.cp_din, '0);
    chk("rst_tx_frame", bus.tx_frame, '0);
    rst = 1'b1;
    run(2);

    // manual edge with frame_count == 0 must not send
    clr();
    manual_send = 1'b1; tick(); manual_send = 1'b0;
    run(5);
    chk("man0_trig", FB'(n_trig), '0);
    chk("man0_busy", FB'(busy), '0);

    // coprocessor never answers
    clr();
    cp_delay = 0; tx_len = 4;
    push(fi);
    run(4);
    for (int g = 0; g < 200 && cyc < val_cyc + 63; g++) tick();
    chk("cto_err_early", FB'(err_timeout), '0);
    tick();
    chk("cto_err", FB'(err_timeout), FB'(1));
    chk("cto_busy", FB'(busy), '0);
    chk("cto_trig", FB'(n_trig), '0);
    chk("cto_cnt", FB'(frame_count), '0);
    chk("cto_tx_frame", bus.tx_frame, '0);
    run(3);

    // normal echo frame after a timeout
    clr();
    cp_delay = 5; cp_mask = '0; tx_len = 20;
    push(fa);
    run(60);
    chk("t1_rd", FB'(n_rd), FB'(1));
    chk("t1_val", FB'(n_val), FB'(1));
    chk("t1_trig", FB'(n_trig), FB'(1));
    chk("t1_cp_din", bus.cp_din, fa);
    chk("t1_tx_frame", bus.tx_frame, fa);
    chk("t1_last_tx", last_tx, fa);
    chk("t1_cnt", FB'(frame_count), FB'(1));
    chk("t1_busy", FB'(busy), '0);
    chk("t1_err_sticky", FB'(err_timeout), FB'(1));

    // pipeline latency with a one-cycle coprocessor
    clr();
    cp_delay = 1; cp_mask = m; tx_len = 3;
    push(fb_);
    run(20);
    chk("lat_val", FB'(val_cyc - rd_cyc), FB'(2));
    chk("lat_trig", FB'(trig_cyc - rd_cyc), FB'(4));
    chk("lat_tx_frame", bus.tx_frame, fb_ ^ m);
    chk("lat_cnt", FB'(frame_count), FB'(2));

    // three queued frames
    clr();
    cp_delay = 3; tx_len = 5;
    push(fc); push(fd); push(fe);
    run(100);
    chk("b3_rd", FB'(n_rd), FB'(3));
    chk("b3_val", FB'(n_val), FB'(3));
    chk("b3_trig", FB'(n_trig), FB'(3));
    chk("b3_serial", FB'(viol), '0);
    chk("b3_cnt", FB'(frame_count), FB'(5));
    chk("b3_cp_din", bus.cp_din, fe);
    chk("b3_tx_frame", bus.tx_frame, fe ^ m);

    // dout_valid coincident with din_valid is ignored
    clr();
    cp_early = 1'b1; cp_delay = 4;
    push(ff);
    run(40);
    cp_early = 1'b0;
    chk("early_tx_frame", bus.tx_frame, ff ^ m);
    chk("early_trig", FB'(n_trig), FB'(1));
    chk("early_cnt", FB'(frame_count), FB'(6));

    // manual resend of last result
    clr();
    tx_len = 4;
    manual_send = 1'b1; tick(); manual_send = 1'b0;
    run(20);
    chk("man_trig", FB'(n_trig), FB'(1));
    chk("man_last_tx", last_tx, ff ^ m);
    chk("man_rd", FB'(n_rd), '0);
    chk("man_cnt", FB'(frame_count), FB'(7));

    // transmitter busy on entry to SEND
    clr();
    tx_force = 1'b1; tx_len = 3; cp_delay = 2;
    push(fg);
    run(15);
    chk("hold_no_trig", FB'(n_trig), '0);
    rel = cyc;
    tx_force = 1'b0;
    run(15);
    chk("hold_trig_cyc", FB'(trig_cyc - rel), FB'(1));
    chk("hold_trig", FB'(n_trig), FB'(1));
    chk("hold_cnt", FB'(frame_count), FB'(8));

    // transmitter never acknowledges (fresh reset so err starts clear)
    rst = 1'b0; run(2); rst = 1'b1; run(2);
    clr();
    tx_len = 0; cp_delay = 2;
    push(fh);
    run(12);
    for (int g = 0; g < 200 && cyc < trig_cyc + 15; g++) tick();
    chk("ack_err_early", FB'(err_timeout), '0);
    tick();
    chk("ack_err", FB'(err_timeout), FB'(1));
    chk("ack_busy", FB'(busy), '0);
    chk("ack_trig", FB'(n_trig), FB'(1));
    chk("ack_cnt", FB'(frame_count), '0);
    chk("ack_tx_frame", bus.tx_frame, fh ^ m);
    run(3);

    // asynchronous reset during COMPUTE
    clr();
    cp_delay = 6; tx_len = 4;
    push(fj);
    run(5);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", FB'(busy), '0);
    chk("arst_err", FB'(err_timeout), '0);
    chk("arst_cnt", FB'(frame_count), '0);
    chk("arst_cp_din", bus.cp_din, '0);
    chk("arst_tx_frame", bus.tx_frame, '0);
    chk("arst_val", FB'(bus.cp_din_valid), '0);
    run(2);
    rst = 1'b1;
    run(30);
    chk("arst_late_trig", FB'(n_trig), '0);
    chk("arst_late_cnt", FB'(frame_count), '0);
    chk("arst_late_busy", FB'(busy), '0);
    chk("arst_late_rd", FB'(n_rd), FB'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coproc_frame_sequencer.md
Name: coproc_frame_sequencer

Overview:
- Sequences a single UART-frame/coprocessor transaction: pops a received frame from the UART RX side, presents it to the coprocessor with a one-cycle din_valid, and waits for dout_valid.
- Latches the result and fires the UART TX trigger, then waits for the transmitter to finish.
- Arbitrates a manual "resend last result" request (button) against the automatic path.
- Sits in top between uart_top and coprocessor; replaces the direct wiring and the hard-tied din_valid.

Parameters:
- FRAME_BITS, 144, frame width in bits (UART_FRAME_SIZE*DBITS).
- TIMEOUT_CYCLES, 1_000_000, maximum cycles to wait in COMPUTE for cp_dout_valid.
- TX_ACK_CYCLES, 16, maximum cycles to wait for tx_busy to rise after tx_trigger.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- rx_empty  in  1  UART RX FIFO empty.
- rx_frame  in  FRAME_BITS  head frame of the UART RX FIFO.
- rx_rd  out  1  one-cycle pop strobe to the RX FIFO.
- cp_din  out  FRAME_BITS  registered frame to the coprocessor.
- cp_din_valid  out  1  one-cycle valid to the coprocessor.
- cp_dout  in  FRAME_BITS  coprocessor result.
- cp_dout_valid  in  1  result valid (may be a single-cycle pulse).
- tx_frame  out  FRAME_BITS  registered result to the UART TX.
- tx_trigger  out  1  one-cycle send strobe to the UART.
- tx_busy  in  1  UART transmitter busy.
- manual_send  in  1  synchronised level request; edge-detected internally.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky; set on coprocessor or TX-ack timeout.
- frame_count  out  CNT_W  completed transactions, wraps at 2^CNT_W.

Behaviour:
- Reset (rst=0, async): state=IDLE; all strobes 0; cp_din=0; tx_frame=0; err_timeout=0; frame_count=0; timeout counter=0; manual edge register=0.
- Reset asserted mid-transaction aborts immediately. No pop and no trigger is issued after release until a new IDLE decision.
- IDLE:
  - If !rx_empty: assert rx_rd for 1 cycle and go to LOAD. The automatic path has priority.
  - Else if a manual_send rising edge occurs and frame_count != 0: go to SEND with tx_frame unchanged (resend).
  - A manual edge arriving while not in IDLE, or while RX has data, is dropped, not queued.
- LOAD (1 cycle): cp_din <= rx_frame sampled in the rx_rd cycle, i.e. the head frame before the pop. Go to ISSUE.
- ISSUE (1 cycle): cp_din_valid=1; clear the timeout counter; go to COMPUTE.
- COMPUTE:
  - cp_dout_valid=1: tx_frame <= cp_dout; go to SEND. cp_dout_valid asserted in the same cycle as cp_din_valid is ignored.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no valid: set err_timeout, go to IDLE. tx_frame is unchanged and frame_count does not increment.
- SEND:
  - Wait while tx_busy=1.
  - When tx_busy=0: tx_trigger=1 for 1 cycle, clear the counter, go to TX_ACK.
- TX_ACK:
  - tx_busy=1: go to TX_DRAIN.
  - TX_ACK_CYCLES elapse without tx_busy: set err_timeout, go to IDLE without incrementing.
- TX_DRAIN:
  - Wait for tx_busy=0, then frame_count += 1 (modulo wrap) and go to IDLE.
  - The manual resend path also increments frame_count.
- Latency, automatic path: rx_rd at cycle T, cp_din valid at T+1, cp_din_valid at T+2. With result at T+3 and tx_busy=0, tx_trigger occurs at T+4.
- All outputs are registered; strobes are never wider than 1 cycle.
- err_timeout clears only on reset.

Test Plan:
- One frame 0x01..0x12 queued, coprocessor echoes after 5 cycles, tx_busy held for 20 cycles after trigger -> one rx_rd, one cp_din_valid, cp_din=frame, one tx_trigger, tx_frame=echo, frame_count=1, busy low after drain.
- Three frames back-to-back in the FIFO -> exactly three rx_rd/cp_din_valid/tx_trigger, strictly serialised (no new rx_rd while busy), frame_count=3.
- Coprocessor never asserts dout_valid, TIMEOUT_CYCLES=64 -> err_timeout=1 at ISSUE+64, no tx_trigger, frame_count=0. A following frame processes normally and err_timeout stays 1.
- After one completed frame, pulse manual_send with RX empty -> tx_trigger with the identical tx_frame, frame_count=2. Manual edge when frame_count=0 -> no trigger.
- tx_busy high on entry to SEND for 10 cycles -> tx_trigger only on the first cycle tx_busy=0. tx_busy never rises after trigger, TX_ACK_CYCLES=16 -> err_timeout=1, return to IDLE.
- Assert rst low during COMPUTE -> all outputs zero asynchronously. Late cp_dout_valid after release is ignored: no tx_trigger, frame_count=0.
